// File: rtl/definitions_pkg.sv
// definitions_pkg
//   Shared definitions for the UART byte receiver: default line timing and
//   the receive FSM state encoding.
package definitions_pkg;

  localparam int UART_CLKS_PER_BIT = 32;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

endpackage : definitions_pkg

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
//   Two-flop synchronizer for a single asynchronous input. Both flops load
//   RESET_VAL during reset so the output sits at the line's idle level.
//
// Ports
//   clk      : system clock
//   rstN     : synchronous active-low reset
//   async_i  : asynchronous input
//   sync_o   : synchronized copy of async_i, two clocks of latency
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstN,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule : uart_rx_sync

// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver
//   UART receive front end: 1 start bit, DATA_BITS data bits LSB first,
//   1 stop bit, idle high. Bits are sampled at their mid-point by a counter
//   running at CLKS_PER_BIT clocks per bit. Completed bytes land in a single
//   holding register delivered over a valid/ready handshake.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   WAIT_IDLE | after reset or a break: wait for the line to read high
//   IDLE      | line idle, looking for a start edge
//   START     | half-bit wait, confirm start bit still low
//   DATA      | sample DATA_BITS data bits at bit mid-points
//   STOP      | sample stop bit; deliver byte or flag a framing error
//
// Ports
//   clk        : system clock
//   rstN       : synchronous active-low reset
//   rx         : asynchronous serial input, idle high
//   data_out   : received byte, stable while data_valid=1
//   data_valid : holding register full
//   data_ready : consumer accepts data_out this cycle
//   frame_err  : one-cycle pulse when the stop bit reads 0
//   overrun    : sticky, a completed byte was dropped
//   err_clr    : clears overrun (a simultaneous new overrun wins)
//   busy       : FSM is inside a frame (not IDLE / WAIT_IDLE)
module uart_byte_receiver
  import definitions_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 err_clr,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_TC   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TC   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(2);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  logic rxs;

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .rstN    (rstN),
    .async_i (rx),
    .sync_o  (rxs)
  );

  uart_rx_state_t       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q,  ferr_d;
  logic                 ovr_q,   ovr_d;
  logic                 load_byte;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= WAIT_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    ferr_d    = 1'b0;
    load_byte = 1'b0;

    unique case (state_q)
      // The synchronizer flops come out of reset holding 1, not the real
      // line level. Let those values drain before trusting rxs, otherwise a
      // reset released mid-frame would resync onto a data bit.
      WAIT_IDLE: begin
        if (cnt_q != SETTLE_TC) begin
          cnt_d = cnt_q + 1'b1;
        end else if (rxs) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == HALF_TC) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == FULL_TC) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Leave at the stop-bit mid-point so a start edge arriving right
      // after the stop bit (no idle gap) is still seen from IDLE.
      STOP: begin
        if (cnt_q == FULL_TC) begin
          cnt_d = '0;
          if (rxs) begin
            load_byte = 1'b1;
            state_d   = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = WAIT_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register. A load while full is only accepted if the current
  // byte is leaving in the same cycle; otherwise the new byte is dropped.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
    if (err_clr) begin
      ovr_d = 1'b0;
    end
    if (load_byte) begin
      if (!valid_q || data_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE) && (state_q != WAIT_IDLE);

endmodule : uart_byte_receiver

// File: tb/tb_uart_byte_receiver.sv
// tb_uart_byte_receiver
//   Directed bench for uart_byte_receiver at 32 clocks per bit.
module tb_uart_byte_receiver;

  localparam int CPB = 32;

  logic       clk = 1'b0;
  logic       rstN;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;
  logic       busy;

  int errors = 0;
  int checks = 0;

  uart_byte_receiver dut (
    .clk        (clk),
    .rstN       (rstN),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor, sampled on the falling edge.
  logic [7:0] got_q[$];
  int         valid_cycles  = 0;
  int         ferr_cnt      = 0;
  int         ferr_run      = 0;
  int         ferr_max      = 0;
  int         hold_viol     = 0;
  int         last_rise_cyc = -1;
  logic       prev_valid    = 1'b0;
  logic       prev_hold     = 1'b0;
  logic [7:0] prev_data     = 8'h00;

  always @(negedge clk) begin
    if (data_valid === 1'b1 && prev_valid !== 1'b1) last_rise_cyc = cyc;
    prev_valid = data_valid;
    if (data_valid === 1'b1) valid_cycles++;
    if (data_valid === 1'b1 && data_ready === 1'b1) got_q.push_back(data_out);
    if (prev_hold && data_out !== prev_data) hold_viol++;
    prev_hold = (data_valid === 1'b1) && (data_ready === 1'b0);
    prev_data = data_out;
    if (frame_err === 1'b1) begin
      ferr_cnt++;
      ferr_run++;
      if (ferr_run > ferr_max) ferr_max = ferr_run;
    end else begin
      ferr_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // All rx drivers start and end at 1 ns after a rising edge.
  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] got_at(input int idx);
    if (idx < got_q.size()) return got_q[idx];
    return 8'hxx;
  endfunction

  int base_q, base_v, base_f, t0, lat;

  initial begin
    rstN       = 1'b0;
    rx         = 1'b1;
    data_ready = 1'b1;
    err_clr    = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data_out",   32'(data_out),   32'h00);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_frame_err",  32'(frame_err),  32'h0);
    check("rst_overrun",    32'(overrun),    32'h0);
    check("rst_busy",       32'(busy),       32'h0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    idle(10);

    // Single byte A5, latency and one-cycle valid
    base_q = got_q.size(); base_v = valid_cycles; base_f = ferr_cnt;
    t0 = cyc;
    send_byte(8'hA5, 1'b1);
    idle(5);
    lat = last_rise_cyc - t0;
    check("a5_count",      32'(got_q.size() - base_q),        32'd1);
    check("a5_data",       32'(got_at(base_q)),               32'hA5);
    check("a5_valid_len",  32'(valid_cycles - base_v),        32'd1);
    check("a5_latency_ok", 32'((lat >= 305) && (lat <= 309)), 32'd1);
    check("a5_frame_err",  32'(ferr_cnt - base_f),            32'd0);

    // Back-to-back 00, FF, 3C with no idle gap
    base_q = got_q.size(); base_v = valid_cycles;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b1);
    idle(10);
    check("b2b_count",   32'(got_q.size() - base_q), 32'd3);
    check("b2b_data0",   32'(got_at(base_q)),        32'h00);
    check("b2b_data1",   32'(got_at(base_q + 1)),    32'hFF);
    check("b2b_data2",   32'(got_at(base_q + 2)),    32'h3C);
    check("b2b_vcycles", 32'(valid_cycles - base_v), 32'd3);
    check("b2b_overrun", 32'(overrun),               32'h0);

    // Overrun: consumer stalled across two bytes
    base_q = got_q.size();
    data_ready = 1'b0;
    send_byte(8'h12, 1'b1);
    idle(5);
    check("ovr_after_first", 32'(overrun), 32'h0);
    send_byte(8'h34, 1'b1);
    idle(5);
    check("ovr_valid",    32'(data_valid),            32'h1);
    check("ovr_data_out", 32'(data_out),              32'h12);
    check("ovr_set",      32'(overrun),               32'h1);
    check("ovr_no_xfer",  32'(got_q.size() - base_q), 32'd0);
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_xfer_count",  32'(got_q.size() - base_q), 32'd1);
    check("ovr_xfer_data",   32'(got_at(base_q)),        32'h12);
    check("ovr_valid_drop",  32'(data_valid),            32'h0);
    check("ovr_sticky",      32'(overrun),               32'h1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("ovr_cleared",   32'(overrun),   32'h0);
    check("hold_stable",   32'(hold_viol), 32'd0);

    // Framing error, then recovery
    base_q = got_q.size(); base_v = valid_cycles; base_f = ferr_cnt;
    send_byte(8'h55, 1'b0);
    idle(40);
    check("ferr_count",    32'(ferr_cnt - base_f),     32'd1);
    check("ferr_width",    32'(ferr_max),              32'd1);
    check("ferr_no_valid", 32'(valid_cycles - base_v), 32'd0);
    send_byte(8'h66, 1'b1);
    idle(10);
    check("ferr_rec_count", 32'(got_q.size() - base_q), 32'd1);
    check("ferr_rec_data",  32'(got_at(base_q)),        32'h66);

    // Short glitch on rx
    base_v = valid_cycles; base_f = ferr_cnt;
    rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("glitch_busy_mid", 32'(busy), 32'h1);
    idle(40);
    check("glitch_busy_end", 32'(busy),                   32'h0);
    check("glitch_no_valid", 32'(valid_cycles - base_v), 32'd0);
    check("glitch_no_ferr",  32'(ferr_cnt - base_f),     32'd0);

    // Reset in the middle of C3 (bit 2, line low), released while low
    base_q = got_q.size(); base_v = valid_cycles;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rx = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;
    repeat (CPB - 13) @(posedge clk);
    #1;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    idle(10);
    check("rstmid_no_valid", 32'(valid_cycles - base_v), 32'd0);
    check("rstmid_busy",     32'(busy),                   32'h0);
    send_byte(8'h81, 1'b1);
    idle(10);
    check("rstmid_next_count", 32'(got_q.size() - base_q), 32'd1);
    check("rstmid_next_data",  32'(got_at(base_q)),        32'h81);
    check("final_hold_stable", 32'(hold_viol),             32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_byte_receiver

// File: doc/uart_byte_receiver.md
Name: uart_byte_receiver

Overview:
- RTL UART receive front end of chip_top; converts the serial `rx` pin into bytes for the edge-detection datapath.
- Line format is fixed: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), idle high.
- Bit period is 320 ns at a 10 ns clock, i.e. 32 clocks per bit.
- Received bytes are delivered over a valid/ready handshake with a single holding register; framing and overrun errors are flagged.

Parameters:
- CLKS_PER_BIT, 32, clocks per UART bit; must be even and ≥ 4.
- DATA_BITS, 8, data bits per frame; fixed at 8 in chip_top.

Ports:
- clk  in  1  system clock (the design's only clock).
- rstN  in  1  reset; synchronous, active-low.
- rx  in  1  asynchronous serial input, idle high.
- data_out  out  DATA_BITS  received byte; stable while data_valid=1.
- data_valid  out  1  holding register full.
- data_ready  in  1  consumer accepts data_out this cycle.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  sticky: a completed byte was dropped.
- err_clr  in  1  clears overrun.
- busy  out  1  high in any state other than IDLE and WAIT_IDLE.

Behaviour:
- **Synchronizer.** rx passes through 2 flops before use; both flops reset to 1. Call the synchronized signal rxs.
- **Reset.** While rstN=0 at a clk edge:
  - state goes to WAIT_IDLE; bit counter and index go to 0; shift register goes to 0.
  - data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame discards the partial byte. WAIT_IDLE then prevents resyncing in the middle of a frame.
- **FSM states:** WAIT_IDLE, IDLE, START, DATA, STOP.
  - WAIT_IDLE: go to IDLE when rxs=1.
  - IDLE: when rxs=0, go to START and clear the counter.
  - START: the counter runs 0..CLKS_PER_BIT/2-1. At the terminal count, sample rxs:
    - rxs=0: go to DATA, clear counter and bit index.
    - rxs=1: glitch; return to IDLE and emit no error.
  - DATA: the counter runs 0..CLKS_PER_BIT-1. At the terminal count (bit mid-point):
    - shift right, inserting rxs at the MSB;
    - increment the bit index;
    - after DATA_BITS samples, go to STOP.
  - STOP: at the terminal count, sample rxs:
    - rxs=1: offer the byte to the holding register; go to IDLE immediately so the next start edge is caught during the remaining half stop bit.
    - rxs=0: pulse frame_err for 1 cycle, discard the byte, go to WAIT_IDLE (break condition).
- **Latency.** From the rx pin falling edge to data_valid rising is 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 clocks, which is 307 at default. Benches allow ±2.
- **Holding register and handshake:**
  - A transfer occurs when data_valid & data_ready. On transfer, data_valid deasserts next cycle unless a new byte loads in the same cycle.
  - New byte with data_valid=0 loads; data_valid=1 the next cycle.
  - New byte with data_valid=1 and data_ready=1 in the same cycle: the old byte transfers, the new byte loads, data_valid stays 1, no overrun.
  - New byte with data_valid=1 and data_ready=0: the new byte is dropped, the old byte is retained, overrun is set.
  - data_out must not change while data_valid=1 and data_ready=0.
- **Overrun.** Sticky until err_clr=1 or reset. If err_clr=1 in the same cycle as a new overrun event, the set wins.
- **Back-to-back frames.** A frame with zero idle bits between stop and the next start must be received correctly.

Decomposition:
- Add to definitions_pkg:
  - typedef enum uart_rx_state_t {WAIT_IDLE, IDLE, START, DATA, STOP};
  - localparam UART_CLKS_PER_BIT = 32;
  - localparam UART_DATA_BITS = 8.
- One sub-module: uart_rx_sync, a 2-flop synchronizer with parameterized reset value 1.
- Counter width is $clog2(CLKS_PER_BIT); bit index width is $clog2(DATA_BITS+1).

Test Plan:
- Reset, then send 8'hA5 with 32-clock bits, data_ready=1 → data_out=8'hA5, data_valid high for exactly 1 cycle, 307±2 clocks after the start edge, frame_err=0.
- Send 8'h00, 8'hFF, 8'h3C back-to-back with no idle gap, data_ready=1 → three valid pulses carrying 00, FF, 3C in order, overrun=0.
- Hold data_ready=0, send 8'h12 then 8'h34 → data_out stays 8'h12 with data_valid=1; overrun=1 after the second stop bit. Assert data_ready → 8'h12 transfers. Pulse err_clr → overrun=0.
- Send 8'h55 with the stop bit driven 0 → frame_err single-cycle pulse, no data_valid; a following 8'h66 after the line returns high is received correctly.
- Pulse rx low for 10 clocks (glitch < half bit) → no data_valid, no frame_err, FSM back in IDLE.
- Assert rstN=0 mid-data-bit of 8'hC3, release while rx is low → no byte output. Next complete frame 8'h81 → data_out=8'h81.
